// File: rtl/maq_embalagem.sv
// Packing stage: pushes each finished bottle into a crate, advances the conveyor,
// counts bottles per crate and in total. Optional watchdog: MAQ_EMBALAGEM_WATCHDOG_EN.
module maq_embalagem #(
  parameter int unsigned CAIXA_N = 6,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       gc,
  input  logic       pg,
  input  logic       cx,
  input  logic       ret,
  output logic       empurra,
  output logic       esteira,
  output logic       cx_cheia,
  output logic       falta_cx,
  output logic       alarme,
  output logic [3:0] qtd_caixa,
  output logic [7:0] total,
  output logic [2:0] estado
);

  typedef enum logic [2:0] {
    ESPERA      = 3'b000,
    TRANSFERE   = 3'b001,
    AVANCA      = 3'b010,
    CAIXA_CHEIA = 3'b011,
    TROCA       = 3'b100,
    ERRO        = 3'b101
  } estado_t;

  localparam logic [3:0] L_CAIXA_N = 4'(CAIXA_N);

  if (CAIXA_N < 1 || CAIXA_N > 15 || TIMEOUT < 1 || TIMEOUT > 1023) begin : g_param_err
    $error("maq_embalagem: CAIXA_N must be 1..15 and TIMEOUT 1..1023");
  end

  estado_t    r_estado;
  estado_t    w_prox;
  logic       r_empurra;
  logic       r_esteira;
  logic       r_cx_cheia;
  logic [3:0] r_qtd;
  logic [7:0] r_total;
  logic       w_sai;
  logic [3:0] w_qtd_inc;

  assign w_sai     = ret && !pg;
  assign w_qtd_inc = r_qtd + 4'd1;

`ifdef MAQ_EMBALAGEM_WATCHDOG_EN
  localparam logic [9:0] L_TIMEOUT = 10'(TIMEOUT);
  logic [9:0] r_wd;
  logic [9:0] w_wd_inc;
  logic       r_alarme;
  assign w_wd_inc = r_wd + 10'd1;
  assign alarme   = r_alarme;
`else
  assign alarme = 1'b0;
`endif

  // Next-state logic; the exit condition wins over a simultaneous watchdog expiry.
  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      ESPERA:      if (gc && cx) w_prox = TRANSFERE;
      TRANSFERE: begin
        if (w_sai) begin
          w_prox = (w_qtd_inc == L_CAIXA_N) ? CAIXA_CHEIA : AVANCA;
        end
`ifdef MAQ_EMBALAGEM_WATCHDOG_EN
        else if (w_wd_inc == L_TIMEOUT) begin
          w_prox = ERRO;
        end
`endif
      end
      AVANCA:      if (pg) w_prox = ESPERA;
      CAIXA_CHEIA: if (!cx) w_prox = TROCA;
      TROCA:       if (cx) w_prox = AVANCA;
      ERRO:        w_prox = ERRO;
      default:     w_prox = ESPERA;
    endcase
  end

  // Outputs are registered from the next state so they change with the state itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_estado   <= ESPERA;
      r_empurra  <= 1'b0;
      r_esteira  <= 1'b0;
      r_cx_cheia <= 1'b0;
      r_qtd      <= 4'd0;
      r_total    <= 8'd0;
`ifdef MAQ_EMBALAGEM_WATCHDOG_EN
      r_wd       <= 10'd0;
      r_alarme   <= 1'b0;
`endif
    end else begin
      r_estado   <= w_prox;
      r_empurra  <= (w_prox == TRANSFERE);
      r_esteira  <= (w_prox == AVANCA);
      r_cx_cheia <= (w_prox == CAIXA_CHEIA) || (w_prox == TROCA);
      if (r_estado == TRANSFERE && w_sai) begin
        r_qtd   <= w_qtd_inc;
        r_total <= r_total + 8'd1;
      end else if (r_estado == TROCA && cx) begin
        r_qtd <= 4'd0;
      end
`ifdef MAQ_EMBALAGEM_WATCHDOG_EN
      r_alarme <= (w_prox == ERRO);
      if (r_estado == TRANSFERE) begin
        r_wd <= w_wd_inc;
      end else if (w_prox == TRANSFERE) begin
        r_wd <= 10'd0;
      end
`endif
    end
  end

  assign empurra   = r_empurra;
  assign esteira   = r_esteira;
  assign cx_cheia  = r_cx_cheia;
  assign falta_cx  = reset && (r_estado == ESPERA) && gc && !cx;
  assign qtd_caixa = r_qtd;
  assign total     = r_total;
  assign estado    = r_estado;

endmodule

// File: tb/tb_maq_embalagem.sv
// Directed bench for maq_embalagem (CAIXA_N=6, TIMEOUT=8) plus a CAIXA_N=1 instance.
module tb_maq_embalagem;

  logic       clk = 1'b0;
  logic       reset;
  logic       gc, pg, cx, ret;
  logic       empurra, esteira, cx_cheia, falta_cx, alarme;
  logic [3:0] qtd_caixa;
  logic [7:0] total;
  logic [2:0] estado;
  logic       empurra1, esteira1, cx_cheia1, falta_cx1, alarme1;
  logic [3:0] qtd_caixa1;
  logic [7:0] total1;
  logic [2:0] estado1;

  int n_checks = 0;
  int n_fail   = 0;

  maq_embalagem #(.CAIXA_N(6), .TIMEOUT(8)) u_dut (
    .clk(clk), .reset(reset), .gc(gc), .pg(pg), .cx(cx), .ret(ret),
    .empurra(empurra), .esteira(esteira), .cx_cheia(cx_cheia), .falta_cx(falta_cx),
    .alarme(alarme), .qtd_caixa(qtd_caixa), .total(total), .estado(estado)
  );

  maq_embalagem #(.CAIXA_N(1), .TIMEOUT(8)) u_dut1 (
    .clk(clk), .reset(reset), .gc(gc), .pg(pg), .cx(cx), .ret(ret),
    .empurra(empurra1), .esteira(esteira1), .cx_cheia(cx_cheia1), .falta_cx(falta_cx1),
    .alarme(alarme1), .qtd_caixa(qtd_caixa1), .total(total1), .estado(estado1)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; gc = 1'b0; cx = 1'b1; ret = 1'b0; pg = 1'b1;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  // Push one bottle from ESPERA; ends in AVANCA or CAIXA_CHEIA.
  task automatic bottle();
    gc = 1'b1; step();
    gc = 1'b0; pg = 1'b0; ret = 1'b1; step();
    ret = 1'b0;
  endtask

  task automatic finish_avanca();
    pg = 1'b1; step();
  endtask

  task automatic swap();
    cx = 1'b0; step();
    cx = 1'b1; step();
  endtask

  task automatic test_reset();
    reset = 1'b0; gc = 1'b1; cx = 1'b0; ret = 1'b0; pg = 1'b1;
    #1;
    n_checks++; if (estado !== 3'd0) begin n_fail++; $display("FAIL reset_estado: got %0d want 0", estado); end
    n_checks++; if (qtd_caixa !== 4'd0 || total !== 8'd0) begin n_fail++; $display("FAIL reset_counts: got qtd=%0d total=%0d want 0/0", qtd_caixa, total); end
    n_checks++; if ({empurra, esteira, cx_cheia, falta_cx, alarme} !== 5'b0) begin n_fail++; $display("FAIL reset_bits: got %b want 00000", {empurra, esteira, cx_cheia, falta_cx, alarme}); end
    step();
    reset = 1'b1; gc = 1'b0; cx = 1'b1;
    step();
  endtask

  task automatic test_single();
    do_reset();
    gc = 1'b1; step();
    n_checks++; if (empurra !== 1'b1 || estado !== 3'd1) begin n_fail++; $display("FAIL single_push_start: got empurra=%b estado=%0d want 1/1", empurra, estado); end
    gc = 1'b0; pg = 1'b0;
    repeat (3) step();
    n_checks++; if (empurra !== 1'b1 || total !== 8'd0) begin n_fail++; $display("FAIL single_push_hold: got empurra=%b total=%0d want 1/0", empurra, total); end
    ret = 1'b1; step();
    n_checks++; if (empurra !== 1'b0 || esteira !== 1'b1 || estado !== 3'd2) begin n_fail++; $display("FAIL single_exit: got empurra=%b esteira=%b estado=%0d want 0/1/2", empurra, esteira, estado); end
    n_checks++; if (qtd_caixa !== 4'd1 || total !== 8'd1) begin n_fail++; $display("FAIL single_count: got qtd=%0d total=%0d want 1/1", qtd_caixa, total); end
    ret = 1'b0; step();
    n_checks++; if (esteira !== 1'b1 || estado !== 3'd2) begin n_fail++; $display("FAIL single_avanca_hold: got esteira=%b estado=%0d want 1/2", esteira, estado); end
    pg = 1'b1; step();
    n_checks++; if (esteira !== 1'b0 || estado !== 3'd0) begin n_fail++; $display("FAIL single_back_espera: got esteira=%b estado=%0d want 0/0", esteira, estado); end
  endtask

  task automatic test_crate();
    do_reset();
    repeat (5) begin bottle(); finish_avanca(); end
    n_checks++; if (qtd_caixa !== 4'd5 || estado !== 3'd0) begin n_fail++; $display("FAIL crate_five: got qtd=%0d estado=%0d want 5/0", qtd_caixa, estado); end
    bottle();
    n_checks++; if (estado !== 3'd3 || cx_cheia !== 1'b1 || esteira !== 1'b0 || empurra !== 1'b0) begin n_fail++; $display("FAIL crate_full: got estado=%0d cx_cheia=%b esteira=%b empurra=%b want 3/1/0/0", estado, cx_cheia, esteira, empurra); end
    n_checks++; if (qtd_caixa !== 4'd6 || total !== 8'd6) begin n_fail++; $display("FAIL crate_full_count: got qtd=%0d total=%0d want 6/6", qtd_caixa, total); end
    pg = 1'b1; step();
    n_checks++; if (estado !== 3'd3) begin n_fail++; $display("FAIL crate_wait_cx: got estado=%0d want 3", estado); end
    cx = 1'b0; step();
    n_checks++; if (estado !== 3'd4 || cx_cheia !== 1'b1) begin n_fail++; $display("FAIL crate_troca: got estado=%0d cx_cheia=%b want 4/1", estado, cx_cheia); end
    cx = 1'b1; step();
    n_checks++; if (estado !== 3'd2 || esteira !== 1'b1 || cx_cheia !== 1'b0) begin n_fail++; $display("FAIL crate_new: got estado=%0d esteira=%b cx_cheia=%b want 2/1/0", estado, esteira, cx_cheia); end
    n_checks++; if (qtd_caixa !== 4'd0 || total !== 8'd6) begin n_fail++; $display("FAIL crate_new_count: got qtd=%0d total=%0d want 0/6", qtd_caixa, total); end
    finish_avanca();
    n_checks++; if (estado !== 3'd0) begin n_fail++; $display("FAIL crate_espera: got estado=%0d want 0", estado); end
  endtask

  task automatic test_falta_cx();
    do_reset();
    gc = 1'b1; cx = 1'b0; #1;
    n_checks++; if (falta_cx !== 1'b1 || estado !== 3'd0 || empurra !== 1'b0 || esteira !== 1'b0) begin n_fail++; $display("FAIL falta_cx_set: got falta=%b estado=%0d empurra=%b esteira=%b want 1/0/0/0", falta_cx, estado, empurra, esteira); end
    step();
    n_checks++; if (falta_cx !== 1'b1 || estado !== 3'd0) begin n_fail++; $display("FAIL falta_cx_stay: got falta=%b estado=%0d want 1/0", falta_cx, estado); end
    cx = 1'b1; #1;
    n_checks++; if (falta_cx !== 1'b0) begin n_fail++; $display("FAIL falta_cx_clear: got %b want 0", falta_cx); end
    step();
    n_checks++; if (empurra !== 1'b1 || estado !== 3'd1) begin n_fail++; $display("FAIL falta_cx_push: got empurra=%b estado=%0d want 1/1", empurra, estado); end
    gc = 1'b0;
  endtask

  task automatic test_ret_with_pg();
    do_reset();
    gc = 1'b1; step();
    gc = 1'b0; ret = 1'b1; pg = 1'b1;
    step(); step();
    n_checks++; if (estado !== 3'd1 || empurra !== 1'b1 || total !== 8'd0 || qtd_caixa !== 4'd0) begin n_fail++; $display("FAIL ret_pg_ignored: got estado=%0d empurra=%b total=%0d qtd=%0d want 1/1/0/0", estado, empurra, total, qtd_caixa); end
    pg = 1'b0; step();
    n_checks++; if (estado !== 3'd2 || total !== 8'd1 || qtd_caixa !== 4'd1) begin n_fail++; $display("FAIL ret_pg_count: got estado=%0d total=%0d qtd=%0d want 2/1/1", estado, total, qtd_caixa); end
    step();
    n_checks++; if (total !== 8'd1 || qtd_caixa !== 4'd1) begin n_fail++; $display("FAIL ret_no_double: got total=%0d qtd=%0d want 1/1", total, qtd_caixa); end
    ret = 1'b0; finish_avanca();
  endtask

  task automatic test_caixa_n1();
    do_reset();
    bottle();
    n_checks++; if (estado1 !== 3'd3 || qtd_caixa1 !== 4'd1 || cx_cheia1 !== 1'b1) begin n_fail++; $display("FAIL n1_full: got estado=%0d qtd=%0d cx_cheia=%b want 3/1/1", estado1, qtd_caixa1, cx_cheia1); end
    n_checks++; if (estado !== 3'd2) begin n_fail++; $display("FAIL n6_not_full: got estado=%0d want 2", estado); end
  endtask

  task automatic test_watchdog();
    do_reset();
    gc = 1'b1; step();
    gc = 1'b0; pg = 1'b0; ret = 1'b0;
    repeat (7) step();
    n_checks++; if (estado !== 3'd1 || alarme !== 1'b0) begin n_fail++; $display("FAIL wd_before: got estado=%0d alarme=%b want 1/0", estado, alarme); end
    step();
`ifdef MAQ_EMBALAGEM_WATCHDOG_EN
    n_checks++; if (estado !== 3'd5 || alarme !== 1'b1 || empurra !== 1'b0) begin n_fail++; $display("FAIL wd_erro: got estado=%0d alarme=%b empurra=%b want 5/1/0", estado, alarme, empurra); end
    gc = 1'b1; ret = 1'b1;
    repeat (5) step();
    n_checks++; if (estado !== 3'd5 || alarme !== 1'b1 || total !== 8'd0) begin n_fail++; $display("FAIL wd_hold: got estado=%0d alarme=%b total=%0d want 5/1/0", estado, alarme, total); end
    reset = 1'b0; #1;
    n_checks++; if (estado !== 3'd0 || alarme !== 1'b0) begin n_fail++; $display("FAIL wd_reset: got estado=%0d alarme=%b want 0/0", estado, alarme); end
`else
    n_checks++; if (estado !== 3'd1 || alarme !== 1'b0) begin n_fail++; $display("FAIL wd_off_wait: got estado=%0d alarme=%b want 1/0", estado, alarme); end
    repeat (20) step();
    n_checks++; if (estado !== 3'd1 || empurra !== 1'b1) begin n_fail++; $display("FAIL wd_off_long: got estado=%0d empurra=%b want 1/1", estado, empurra); end
    ret = 1'b1; step();
    n_checks++; if (estado !== 3'd2 || total !== 8'd1) begin n_fail++; $display("FAIL wd_off_exit: got estado=%0d total=%0d want 2/1", estado, total); end
`endif
    ret = 1'b0; gc = 1'b0;
  endtask

  task automatic test_wrap_and_reset();
    int exp_qtd;
    do_reset();
    exp_qtd = 0;
    for (int i = 0; i < 256; i++) begin
      bottle();
      exp_qtd++;
      if (exp_qtd == 6) begin swap(); exp_qtd = 0; end
      finish_avanca();
      if (i == 254) begin
        n_checks++; if (total !== 8'd255) begin n_fail++; $display("FAIL wrap_255: got %0d want 255", total); end
      end
    end
    n_checks++; if (total !== 8'd0 || qtd_caixa !== 4'(exp_qtd) || estado !== 3'd0) begin n_fail++; $display("FAIL wrap_0: got total=%0d qtd=%0d estado=%0d want 0/%0d/0", total, qtd_caixa, estado, exp_qtd); end
    gc = 1'b1; step();
    n_checks++; if (empurra !== 1'b1) begin n_fail++; $display("FAIL mid_push: got empurra=%b want 1", empurra); end
    reset = 1'b0; #1;
    n_checks++; if ({empurra, esteira, cx_cheia, falta_cx, alarme} !== 5'b0 || estado !== 3'd0) begin n_fail++; $display("FAIL mid_reset_bits: got %b estado=%0d want 00000/0", {empurra, esteira, cx_cheia, falta_cx, alarme}, estado); end
    n_checks++; if (qtd_caixa !== 4'd0 || total !== 8'd0) begin n_fail++; $display("FAIL mid_reset_counts: got qtd=%0d total=%0d want 0/0", qtd_caixa, total); end
    gc = 1'b0; step();
    reset = 1'b1; step();
  endtask

  initial begin
    reset = 1'b0; gc = 1'b0; cx = 1'b1; ret = 1'b0; pg = 1'b1;
    test_reset();
    test_single();
    test_crate();
    test_falta_cx();
    test_ret_with_pg();
    test_caixa_n1();
    test_watchdog();
    test_wrap_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
